// File: rtl/scpad_addr_seq.sv
// scpad_addr_seq: self-sequencing scratchpad address stage.
// Takes one tile request, walks every beat of the tile, and emits one
// registered per-bank crossbar descriptor per beat over valid/ready.
module scpad_addr_seq #(
  parameter int NUM_BANKS  = 32,
  parameter int SLOT_W     = 10,
  parameter int DIM_W      = $clog2(NUM_BANKS) + 1,
  parameter int ID_W       = 4,
  parameter int SWIZZLE_EN = 1
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_row_or_col,
  input  logic [SLOT_W-1:0]                     req_base,
  input  logic [DIM_W-1:0]                      req_num_rows,
  input  logic [DIM_W-1:0]                      req_num_cols,
  input  logic [ID_W-1:0]                       req_id,
  output logic                                  desc_valid,
  input  logic                                  desc_ready,
  output logic [NUM_BANKS*SLOT_W-1:0]           desc_slot_mask,
  output logic [NUM_BANKS-1:0]                  desc_valid_mask,
  output logic [NUM_BANKS*$clog2(NUM_BANKS)-1:0] desc_shift_mask,
  output logic [DIM_W-1:0]                      desc_idx,
  output logic                                  desc_last,
  output logic [ID_W-1:0]                       desc_id,
  output logic                                  err_pulse,
  output logic                                  busy
);

  localparam int BIDX_W = $clog2(NUM_BANKS);
  localparam logic [DIM_W:0] NB_EXT = (DIM_W + 1)'(NUM_BANKS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                         state_q, state_d;
  logic                           mode_q, mode_d;
  logic [SLOT_W-1:0]              base_q, base_d;
  logic [DIM_W-1:0]               rows_q, rows_d;
  logic [DIM_W-1:0]               cols_q, cols_d;
  logic [NUM_BANKS*SLOT_W-1:0]    slot_q, slot_d;
  logic [NUM_BANKS-1:0]           vmask_q, vmask_d;
  logic [NUM_BANKS*BIDX_W-1:0]    shift_q, shift_d;
  logic [DIM_W-1:0]               idx_q, idx_d;
  logic                           last_q, last_d;
  logic [ID_W-1:0]                id_q, id_d;
  logic                           err_q, err_d;

  // Descriptor generator inputs: the new request while idle, the latched tile otherwise
  logic                           gen_mode;
  logic [SLOT_W-1:0]              gen_base;
  logic [DIM_W-1:0]               gen_rows;
  logic [DIM_W-1:0]               gen_cols;
  logic [DIM_W-1:0]               gen_k;
  logic [DIM_W-1:0]               gen_n;
  logic                           gen_last;
  logic [SLOT_W-1:0]              row_abs;
  logic [SLOT_W-1:0]              bank_abs;
  logic [BIDX_W-1:0]              lane;
  logic [BIDX_W-1:0]              k_lane;
  logic [NUM_BANKS*SLOT_W-1:0]    gen_slot;
  logic [NUM_BANKS-1:0]           gen_vmask;
  logic [NUM_BANKS*BIDX_W-1:0]    gen_shift;

  logic                           req_legal;
  logic [DIM_W-1:0]               n_q;
  logic                           at_last;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  // desc_valid is exactly "a tile is in flight", so it comes straight from the state flop
  assign desc_valid = (state_q == RUN);

  assign desc_slot_mask  = slot_q;
  assign desc_valid_mask = vmask_q;
  assign desc_shift_mask = shift_q;
  assign desc_idx        = idx_q;
  assign desc_last       = last_q;
  assign desc_id         = id_q;
  assign err_pulse       = err_q;

  assign req_legal = (req_num_rows != '0) && ({1'b0, req_num_rows} <= NB_EXT) &&
                     (req_num_cols != '0) && ({1'b0, req_num_cols} <= NB_EXT);

  assign n_q     = mode_q ? rows_q : cols_q;
  assign at_last = (idx_q == n_q - DIM_W'(1));

  // Select which beat the generator describes: beat 0 of a new request, or the next beat
  always_comb begin
    if (state_q == IDLE) begin
      gen_mode = req_row_or_col;
      gen_base = req_base;
      gen_rows = req_num_rows;
      gen_cols = req_num_cols;
      gen_k    = '0;
    end else begin
      gen_mode = mode_q;
      gen_base = base_q;
      gen_rows = rows_q;
      gen_cols = cols_q;
      gen_k    = idx_q + DIM_W'(1);
    end
    gen_n    = gen_mode ? gen_rows : gen_cols;
    gen_last = (gen_k == gen_n - DIM_W'(1));
  end

  // Per-bank slot / enable / lane computation; disabled banks still get full fields
  always_comb begin
    gen_slot  = '0;
    gen_vmask = '0;
    gen_shift = '0;
    bank_abs  = '0;
    lane      = '0;
    row_abs   = gen_base + SLOT_W'(gen_k);
    k_lane    = gen_k[BIDX_W-1:0];
    for (int b = 0; b < NUM_BANKS; b++) begin
      lane     = BIDX_W'(b);
      bank_abs = gen_base + SLOT_W'(b);
      if (gen_mode) begin
        gen_slot[b*SLOT_W +: SLOT_W]  = row_abs;
        gen_vmask[b]                  = ((DIM_W + 1)'(b) < {1'b0, gen_cols});
        gen_shift[b*BIDX_W +: BIDX_W] = (SWIZZLE_EN != 0) ? (lane ^ row_abs[BIDX_W-1:0]) : lane;
      end else begin
        gen_slot[b*SLOT_W +: SLOT_W]  = bank_abs;
        gen_vmask[b]                  = ((DIM_W + 1)'(b) < {1'b0, gen_rows});
        gen_shift[b*BIDX_W +: BIDX_W] = (SWIZZLE_EN != 0) ? (k_lane ^ bank_abs[BIDX_W-1:0]) : k_lane;
      end
    end
  end

  // Next-state logic: accept/reject requests in IDLE, advance beats on handshake in RUN
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    slot_d  = slot_q;
    vmask_d = vmask_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    last_d  = last_q;
    id_d    = id_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            state_d = RUN;
            mode_d  = req_row_or_col;
            base_d  = req_base;
            rows_d  = req_num_rows;
            cols_d  = req_num_cols;
            id_d    = req_id;
            slot_d  = gen_slot;
            vmask_d = gen_vmask;
            shift_d = gen_shift;
            idx_d   = gen_k;
            last_d  = gen_last;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (desc_ready) begin
          if (at_last) begin
            state_d = IDLE;
          end else begin
            slot_d  = gen_slot;
            vmask_d = gen_vmask;
            shift_d = gen_shift;
            idx_d   = gen_k;
            last_d  = gen_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and descriptor registers; reset clears everything and abandons any tile
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      slot_q  <= '0;
      vmask_q <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      slot_q  <= slot_d;
      vmask_q <= vmask_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_scpad_addr_seq.sv
// tb_scpad_addr_seq: directed plus randomized tiles against a behavioural
// model of the per-beat descriptor rules, on an 8-bank instance.
module tb_scpad_addr_seq;

  localparam int NB    = 8;
  localparam int SW    = 10;
  localparam int DW    = 4;
  localparam int IW    = 4;
  localparam int BW    = 3;

  logic                 CLK;
  logic                 nRST;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_row_or_col;
  logic [SW-1:0]        req_base;
  logic [DW-1:0]        req_num_rows;
  logic [DW-1:0]        req_num_cols;
  logic [IW-1:0]        req_id;
  logic                 desc_valid;
  logic                 desc_ready;
  logic [NB*SW-1:0]     desc_slot_mask;
  logic [NB-1:0]        desc_valid_mask;
  logic [NB*BW-1:0]     desc_shift_mask;
  logic [DW-1:0]        desc_idx;
  logic                 desc_last;
  logic [IW-1:0]        desc_id;
  logic                 err_pulse;
  logic                 busy;

  int vectors;
  int miscompares;

  scpad_addr_seq #(
    .NUM_BANKS(NB), .SLOT_W(SW), .DIM_W(DW), .ID_W(IW), .SWIZZLE_EN(1)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row_or_col(req_row_or_col), .req_base(req_base),
    .req_num_rows(req_num_rows), .req_num_cols(req_num_cols), .req_id(req_id),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_slot_mask(desc_slot_mask), .desc_valid_mask(desc_valid_mask),
    .desc_shift_mask(desc_shift_mask), .desc_idx(desc_idx),
    .desc_last(desc_last), .desc_id(desc_id),
    .err_pulse(err_pulse), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected descriptor for beat k of a tile, straight from the addressing rules
  task automatic checkBeat(input bit mode, input int base, input int rows, input int cols,
                           input int k, input int id);
    logic [NB*SW-1:0] es;
    logic [NB-1:0]    ev;
    logic [NB*BW-1:0] eh;
    int absv, n;
    es = '0; ev = '0; eh = '0;
    n = mode ? rows : cols;
    for (int b = 0; b < NB; b++) begin
      if (mode) begin
        absv = (base + k) % (1 << SW);
        ev[b] = (b < cols);
        eh[b*BW +: BW] = BW'(b ^ (absv % NB));
      end else begin
        absv = (base + b) % (1 << SW);
        ev[b] = (b < rows);
        eh[b*BW +: BW] = BW'(k ^ (absv % NB));
      end
      es[b*SW +: SW] = SW'(absv);
    end
    checkOutput("desc_valid", desc_valid, 1);
    checkOutput("slot_mask", desc_slot_mask, es);
    checkOutput("valid_mask", desc_valid_mask, ev);
    checkOutput("shift_mask", desc_shift_mask, eh);
    checkOutput("desc_idx", desc_idx, k);
    checkOutput("desc_last", desc_last, (k == n - 1));
    checkOutput("desc_id", desc_id, id);
    checkOutput("busy_run", busy, 1);
    checkOutput("req_ready_run", req_ready, 0);
  endtask

  // Offer one tile and follow it to completion; rdyMode 0=always ready, 1=random, 2=pattern
  task automatic applyStimulus(input bit mode, input int base, input int rows, input int cols,
                               input int id, input int rdyMode, input logic [31:0] pat);
    int n, k, cyc;
    n = mode ? rows : cols;
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid      = 1'b1;
    req_row_or_col = mode;
    req_base       = SW'(base);
    req_num_rows   = DW'(rows);
    req_num_cols   = DW'(cols);
    req_id         = IW'(id);
    @(posedge CLK); #1;
    req_valid      = 1'b0;
    req_base       = SW'($urandom);
    req_num_rows   = DW'($urandom);
    req_num_cols   = DW'($urandom);
    req_id         = IW'($urandom);
    req_row_or_col = 1'($urandom);
    k = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      checkBeat(mode, base, rows, cols, k, id);
      case (rdyMode)
        0:       desc_ready = 1'b1;
        1:       desc_ready = 1'($urandom);
        default: desc_ready = pat[cyc % 32];
      endcase
      @(posedge CLK); #1;
      if (desc_ready) k++;
      cyc++;
    end
    checkOutput("tile_timeout", (cyc < 200), 1);
    checkOutput("valid_drop", desc_valid, 0);
    checkOutput("busy_drop", busy, 0);
    checkOutput("req_ready_back", req_ready, 1);
    desc_ready = 1'($urandom);
  endtask

  // Offer an illegal request and confirm it is swallowed with a single error pulse
  task automatic applyIllegal(input int rows, input int cols);
    req_valid      = 1'b1;
    req_row_or_col = 1'($urandom);
    req_base       = SW'($urandom);
    req_num_rows   = DW'(rows);
    req_num_cols   = DW'(cols);
    req_id         = IW'($urandom);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    checkOutput("err_pulse_hi", err_pulse, 1);
    checkOutput("err_no_valid", desc_valid, 0);
    checkOutput("err_no_busy", busy, 0);
    checkOutput("err_ready", req_ready, 1);
    @(posedge CLK); #1;
    checkOutput("err_pulse_lo", err_pulse, 0);
    checkOutput("err_no_valid2", desc_valid, 0);
  endtask

  initial begin
    int m, bs, r, c;
    vectors = 0;
    miscompares = 0;
    nRST = 1'b0;
    req_valid = 1'b1;
    req_row_or_col = 1'b1;
    req_base = 10'd3;
    req_num_rows = 4'd2;
    req_num_cols = 4'd2;
    req_id = 4'd1;
    desc_ready = 1'b1;

    // reset state, with a request offered that must be ignored
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_desc_valid", desc_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_pulse, 0);
    checkOutput("rst_last", desc_last, 0);
    checkOutput("rst_slot", desc_slot_mask, 0);
    checkOutput("rst_vmask", desc_valid_mask, 0);
    checkOutput("rst_shift", desc_shift_mask, 0);
    checkOutput("rst_idx", desc_idx, 0);
    checkOutput("rst_id", desc_id, 0);
    req_valid = 1'b0;
    nRST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("post_rst_idle", desc_valid, 0);

    // row-major base 5, 4x3
    applyStimulus(1'b1, 5, 4, 3, 4'hA, 0, 32'h0);
    // column-major base 2, 8x2
    applyStimulus(1'b0, 2, 8, 2, 4'h3, 0, 32'h0);
    // backpressure pattern 0,0,1,0,1 on a 2-beat tile
    applyStimulus(1'b1, 100, 2, 8, 4'h7, 2, 32'b10100);
    // slot wrap
    applyStimulus(1'b1, 1022, 4, 8, 4'h5, 0, 32'h0);
    // single-beat tiles in both modes
    applyStimulus(1'b1, 17, 1, 5, 4'h9, 0, 32'h0);
    applyStimulus(1'b0, 1020, 8, 1, 4'h2, 1, 32'h0);
    // illegal requests
    applyIllegal(3, 0);
    applyIllegal(NB + 1, 2);
    applyIllegal(0, NB + 1);

    // reset in the middle of an 8-beat tile
    req_valid = 1'b1;
    req_row_or_col = 1'b1;
    req_base = 10'd40;
    req_num_rows = 4'd8;
    req_num_cols = 4'd4;
    req_id = 4'hC;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    desc_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkBeat(1'b1, 40, 8, 4, 2, 4'hC);
    nRST = 1'b0;
    #1;
    checkOutput("midrst_valid", desc_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_idx", desc_idx, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("midrst_no_resume", desc_valid, 0);
    applyStimulus(1'b0, 77, 3, 6, 4'h6, 0, 32'h0);

    // randomized tiles, legal dimensions, random backpressure
    for (int t = 0; t < 24; t++) begin
      m  = int'($urandom_range(0, 1));
      bs = int'($urandom_range(0, (1 << SW) - 1));
      r  = int'($urandom_range(1, NB));
      c  = int'($urandom_range(1, NB));
      applyStimulus(m[0], bs, r, c, int'($urandom_range(0, 15)), 1, 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scpad_addr_seq.md
# scpad_addr_seq

Parametrised, pipelined scratchpad address sequencer. It accepts one tile-access request (base slot, tile dimensions, row- or column-major mode) and walks the whole tile. It emits one registered crossbar descriptor per beat over a valid/ready handshake: per-bank slot, valid and XOR-swizzle shift fields. It sits between the scratchpad backend request queue and the bank crossbar, and replaces per-beat combinational address mapping with a self-sequencing, back-pressurable stage.

## Interface
- NUM_BANKS, 32, bank count. Power of two, ≥ 2. BIDX_W = $clog2(NUM_BANKS).
- SLOT_W, 10, slot (absolute row) index width per bank.
- DIM_W, $clog2(NUM_BANKS)+1, width of tile dimension fields.
- ID_W, 4, request tag width.
- SWIZZLE_EN, 1. When 1, shifts are XOR-swizzled. When 0, shift is identity.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  = (state==IDLE). Combinational.
- req_row_or_col  in  1  1 = row-major (one beat per row), 0 = column-major (one beat per column).
- req_base  in  SLOT_W  base slot of the tile.
- req_num_rows, req_num_cols  in  DIM_W each  tile dimensions, legal range 1..NUM_BANKS.
- req_id  in  ID_W  tag, echoed on every beat.
- desc_valid  out  1  descriptor valid.
- desc_ready  in  1  crossbar accepts the descriptor.
- desc_slot_mask  out  NUM_BANKS*SLOT_W  per-bank slot. Bank b occupies bits [b*SLOT_W +: SLOT_W].
- desc_valid_mask  out  NUM_BANKS  per-bank enable.
- desc_shift_mask  out  NUM_BANKS*BIDX_W  per-bank crossbar lane select.
- desc_idx  out  DIM_W  beat index within the tile.
- desc_last  out  1  final beat of the tile.
- desc_id  out  ID_W  echoed tag.
- err_pulse  out  1  one-cycle pulse on an illegal request.
- busy  out  1  = (state==RUN).

## Operation
- FSM states: IDLE and RUN.
- IDLE → RUN: on req_valid && req_ready with a legal request. Latch mode, base, dims and id. Load beat k=0. Register the beat-0 descriptor. Assert desc_valid.
- RUN, desc_valid && desc_ready with k < N-1: advance k. Register the next descriptor.
- RUN, desc_valid && desc_ready with k == N-1: go to IDLE. desc_valid drops the next cycle.
- Beat count N = num_rows in row-major mode, num_cols in column-major mode.
- Row-major beat k: abs = base + k.
  - slot[b] = abs for every bank.
  - valid[b] = (b < num_cols).
  - shift[b] = b ^ abs[BIDX_W-1:0].
- Column-major beat k: abs_b = base + b.
  - slot[b] = abs_b.
  - valid[b] = (b < num_rows).
  - shift[b] = k ^ abs_b[BIDX_W-1:0].
- SWIZZLE_EN = 0: shift[b] = b in row-major mode, k in column-major mode.
- Slot arithmetic is SLOT_W bits and wraps modulo 2^SLOT_W. No carry out and no error on wrap.
- desc_idx = k. desc_last = (k == N-1). desc_id = the latched tag.
- Descriptor fields for disabled banks (valid[b]=0) are still computed as above. Verification checks them anyway.
- Illegal request: either dimension is 0 or > NUM_BANKS.
  - It is consumed (handshake completes) and err_pulse is high the next cycle.
  - No descriptor is emitted and the state stays IDLE.

## Timing
- Reset values: desc_valid=0, desc_last=0, err_pulse=0, busy=0, all mask/idx/id outputs 0, state=IDLE.
- req_ready reads 1 while in reset. Requests presented during reset are ignored.
- Latency: request accepted at edge t → desc_valid=1 with beat 0 after edge t. All descriptor outputs come straight from flops.
- Throughput: one beat per cycle while desc_ready=1. An N-beat tile occupies N cycles of desc_valid.
- Back-to-back tiles: one dead cycle between them, because req_ready rises only in IDLE.
- Backpressure: while desc_valid && !desc_ready, every desc_* output is held stable. desc_valid never drops without a handshake.
- desc_ready is ignored when desc_valid=0.
- Single-beat tile (N=1): beat 0 carries desc_last=1.
- nRST asserted mid-tile: outputs clear immediately (asynchronous). The tile is abandoned and is not resumed after reset is released.

## Test plan
- Row-major, NUM_BANKS=8, base=5, rows=4, cols=3, desc_ready held 1 → four consecutive beats with slot=5,6,7,8 and valid_mask=0x07.
  - Beat 0 shift = b^5 → lanes {5,4,7,6,1,0,3,2}.
  - Beat 3 carries desc_last=1 and desc_idx=3.
- Column-major, NUM_BANKS=8, base=2, rows=8, cols=2 → two beats, each with slot[b]=2+b and valid_mask=0xFF.
  - Beat 1 shift[b] = 1 ^ ((2+b)&7) → lanes {3,2,5,4,7,6,1,0}.
- Backpressure: desc_ready toggles 0,0,1,0,1 during a 2-beat tile → outputs are held bit-stable while ready=0. Exactly two handshakes occur, and req_ready returns to 1 one cycle after the last handshake.
- Wrap: SLOT_W=10, row-major, base=1022, rows=4 → slots 1022, 1023, 0, 1. No error.
- Illegal request: cols=0, then rows=NUM_BANKS+1 → each is accepted, err_pulse is a single-cycle pulse, desc_valid stays 0, busy stays 0.
- Reset mid-burst: assert nRST low during beat 2 of an 8-beat tile → desc_valid=0 and busy=0 immediately. After release, a new request starts at desc_idx=0 with the new tag.
